mm_stream_master: RTL and testbench
===================================

Name: mm_stream_master

Overview:
- Initiator-side controller for the word-serial Montgomery multiplier interface (mm_start / mm_x / mm_y / mm_result / mm_valid).
- Accepts a full K*N-bit operand pair over a valid/ready handshake, pulses mm_start, then streams N K-bit words of x and y, least significant word first.
- Collects the N-word serial result into a K*N-bit register and presents it over a valid/ready handshake.
- Sits between the modular-exponentiation sequencer and the multiplier core.

Parameters:
- K, 128, word width in bits.
- N, 32, number of words per operand.
- START_GAP, 1, idle cycles between the mm_start pulse and the first data word (0..15).
- TIMEOUT_CYCLES, 4096, watchdog limit; used only with MM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- op_x  in  K*N  operand x, word i = op_x[i*K +: K]
- op_y  in  K*N  operand y, same packing
- op_valid  in  1  operand pair valid
- op_ready  out  1  high only in IDLE
- mm_start  out  1  one-cycle start pulse to the core
- mm_x  out  K  x word
- mm_x_valid  out  1  x word valid
- mm_y  out  K  y word
- mm_y_valid  out  1  y word valid (always equal to mm_x_valid)
- mm_result  in  K  result word from the core
- mm_valid  in  1  result word valid
- res_data  out  K*N  assembled result, word i at [i*K +: K]
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  present only with MM_TIMEOUT_EN

Behaviour:
- Reset (rst_n=1, asynchronous):
  - State is IDLE.
  - mm_start, mm_x_valid, mm_y_valid, res_valid, busy and timeout_err are 0.
  - mm_x, mm_y and res_data are all-zero; word counter is 0.
  - op_ready becomes 1 on the first clock after release.
- Reset asserted mid-operation aborts immediately. Any partial result is discarded and no res_valid is produced.
- All outputs are registered.
- FSM states: IDLE, START, GAP, SEND, WAIT, RECV, DONE.
  - IDLE: op_ready=1. On op_valid&op_ready, latch op_x and op_y into shift registers, clear res_data, go to START.
  - START: mm_start=1 for exactly one cycle. Next state is GAP if START_GAP>0, else SEND.
  - GAP: hold START_GAP cycles with valids low, then go to SEND.
  - SEND: N consecutive cycles with mm_x_valid=mm_y_valid=1. Cycle i drives word i (LSW first). There are no bubbles; the core has no backpressure. After word N-1 the valids drop to 0 and the state goes to WAIT.
  - WAIT: idle until mm_valid=1.
  - RECV: a word is captured on each cycle with mm_valid=1, including the cycle that left WAIT. The capture counter advances only on mm_valid, so gaps in mm_valid are tolerated. The k-th captured word is written to res_data[k*K +: K]. After N captures go to DONE.
  - DONE: res_valid=1 and res_data is stable. On res_valid&res_ready go to IDLE (res_valid=0, op_ready=1) on the next cycle.
- mm_valid outside WAIT/RECV is ignored.
- op_valid outside IDLE is ignored; operands are not re-sampled.
- Latency, op accept to first mm_x_valid: 2+START_GAP cycles (START, GAP cycles, then SEND).
- Back-to-back jobs: the earliest new op accept is the cycle after the res handshake.
- Counters are ceil(log2(N+1)) bits. Word N-1 is the terminal count; there is no wrap-around.

Optional Feature:
- Macro MM_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in WAIT+RECV and clears on entry to WAIT.
  - When it reaches TIMEOUT_CYCLES, the FSM aborts to IDLE and timeout_err pulses 1 for one cycle.
  - res_valid is never asserted for that job, and the partial res_data remains visible but is not valid.
- Not defined: no watchdog and no timeout_err port; WAIT may last indefinitely.

Test Plan:
- K=8,N=4,START_GAP=1: op_x=32'h44332211, op_y=32'h88776655.
  - mm_start high 1 cycle, then 1 gap cycle.
  - Then mm_x = 11,22,33,44 and mm_y = 55,66,77,88 on 4 consecutive cycles with valids high.
- Core model returns 8'hA1,B2,C3,D4 with mm_valid continuous, 10 cycles after the last word.
  - Required: res_data=32'hD4C3B2A1 and res_valid=1 one cycle after the 4th capture.
- mm_valid gapped pattern 1,0,0,1,1,0,1 with words A1,B2,C3,D4: res_data=32'hD4C3B2A1 (zero-valid cycles are ignored).
- res_ready held 0 for 20 cycles: res_valid and res_data are stable, op_ready=0, and a new op_valid is ignored. Releasing res_ready gives op_ready=1 on the next cycle.
- rst_n pulsed during SEND word 2: all valids drop asynchronously, state is IDLE and res_valid=0. A fresh job afterwards completes correctly.
- MM_TIMEOUT_EN, TIMEOUT_CYCLES=16, core never asserts mm_valid: timeout_err pulses once at WAIT cycle 16, the FSM returns to IDLE, and res_valid is never raised.

Source files
------------

// File: rtl/mm_stream_master.sv
// Initiator for the word-serial Montgomery multiplier: streams x/y LSW first, gathers the N-word result.
// Define MM_TIMEOUT_EN to add a WAIT/RECV watchdog and the timeout_err output.
module mm_stream_master #(
    parameter int K              = 128,
    parameter int N              = 32,
    parameter int START_GAP      = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [K*N-1:0] op_x,
    input  logic [K*N-1:0] op_y,
    input  logic           op_valid,
    output logic           op_ready,
    output logic           mm_start,
    output logic [K-1:0]   mm_x,
    output logic           mm_x_valid,
    output logic [K-1:0]   mm_y,
    output logic           mm_y_valid,
    input  logic [K-1:0]   mm_result,
    input  logic           mm_valid,
    output logic [K*N-1:0] res_data,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           busy
`ifdef MM_TIMEOUT_EN
    ,
    output logic           timeout_err
`endif
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {IDLE, START, GAP, SEND, WAIT, RECV, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     gap_q, gap_d;
    logic [K*N-1:0] xsh_q, xsh_d, ysh_q, ysh_d, res_q, res_d;
    logic [K-1:0]   mx_q, mx_d, my_q, my_d;
    logic           start_q, wvld_q, rvld_q, ordy_q, busy_q;
    logic           abort;

`ifdef MM_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          terr_q;

    // Watchdog restarts from zero on every entry to WAIT since it is cleared outside WAIT/RECV.
    assign abort = ((state_q == WAIT) || (state_q == RECV)) && (wd_q == WW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_d = '0;
        if ((state_q == WAIT) || (state_q == RECV)) wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wd_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            terr_q <= abort;
        end
    end

    assign timeout_err = terr_q;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        xsh_d   = xsh_q;
        ysh_d   = ysh_q;
        res_d   = res_q;
        mx_d    = mx_q;
        my_d    = my_q;
        unique case (state_q)
            IDLE: begin
                if (op_valid && ordy_q) begin
                    xsh_d   = op_x;
                    ysh_d   = op_y;
                    res_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                gap_d   = '0;
                cnt_d   = '0;
                state_d = (START_GAP > 0) ? GAP : SEND;
            end
            GAP: begin
                if (gap_q == 4'(START_GAP - 1)) state_d = SEND;
                else                            gap_d   = gap_q + 4'd1;
            end
            SEND: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT, RECV: begin
                // The counter only moves on mm_valid, so bubbles in the result stream are harmless.
                if (mm_valid) begin
                    for (int i = 0; i < N; i++) begin
                        if (cnt_q == CW'(i)) res_d[i*K +: K] = mm_result;
                    end
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = RECV;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
        // Each cycle spent in SEND presents the next low word and shifts the operands down.
        if (state_d == SEND) begin
            mx_d  = xsh_q[K-1:0];
            my_d  = ysh_q[K-1:0];
            xsh_d = xsh_q >> K;
            ysh_d = ysh_q >> K;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            xsh_q   <= '0;
            ysh_q   <= '0;
            res_q   <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            start_q <= 1'b0;
            wvld_q  <= 1'b0;
            rvld_q  <= 1'b0;
            ordy_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            xsh_q   <= xsh_d;
            ysh_q   <= ysh_d;
            res_q   <= res_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            start_q <= (state_d == START);
            wvld_q  <= (state_d == SEND);
            rvld_q  <= (state_d == DONE);
            ordy_q  <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign op_ready   = ordy_q;
    assign mm_start   = start_q;
    assign mm_x       = mx_q;
    assign mm_y       = my_q;
    assign mm_x_valid = wvld_q;
    assign mm_y_valid = wvld_q;
    assign res_data   = res_q;
    assign res_valid  = rvld_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mm_stream_master.sv
// Scoreboard bench for mm_stream_master with K=8, N=4, START_GAP=1, TIMEOUT_CYCLES=16.
module tb_mm_stream_master;
    localparam int K = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [K*N-1:0] op_x = '0, op_y = '0;
    logic           op_valid = 1'b0;
    logic           op_ready;
    logic           mm_start;
    logic [K-1:0]   mm_x, mm_y;
    logic           mm_x_valid, mm_y_valid;
    logic [K-1:0]   mm_result = '0;
    logic           mm_valid = 1'b0;
    logic [K*N-1:0] res_data;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic           busy;
`ifdef MM_TIMEOUT_EN
    logic           timeout_err;
`endif

    int total = 0;
    int bad = 0;

    logic [K-1:0]   exp_x[$];
    logic [K-1:0]   exp_y[$];
    logic [K*N-1:0] exp_res[$];

    mm_stream_master #(.K(K), .N(N), .START_GAP(1), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_x(op_x), .op_y(op_y), .op_valid(op_valid), .op_ready(op_ready),
        .mm_start(mm_start), .mm_x(mm_x), .mm_x_valid(mm_x_valid),
        .mm_y(mm_y), .mm_y_valid(mm_y_valid),
        .mm_result(mm_result), .mm_valid(mm_valid),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy)
`ifdef MM_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one job end to end; abort_at>=0 resets during that SEND word, starve withholds mm_valid.
    task automatic run_job(input logic [31:0] x, input logic [31:0] y, input logic [31:0] r,
                           input bit gapped, input int hold, input int abort_at, input bit starve);
        logic [6:0] gpat;
        logic [7:0] ex, ey;
        logic       v;
        int         t, w, plen;
        gpat = 7'b1011001;
        for (int i = 0; i < N; i++) begin
            exp_x.push_back(x[i*K +: K]);
            exp_y.push_back(y[i*K +: K]);
        end
        res_ready = (hold == 0);
        t = 0;
        while (op_ready !== 1'b1 && t < 50) begin tick(); t++; end
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL op_ready_wait got=%b want=1", op_ready); end
        op_x = x; op_y = y; op_valid = 1'b1;
        tick();
        op_valid = 1'b0; op_x = '1; op_y = '1;
        total++; if (mm_start !== 1'b1 || busy !== 1'b1 || op_ready !== 1'b0) begin bad++;
            $display("FAIL start_pulse got start=%b busy=%b rdy=%b want 1 1 0", mm_start, busy, op_ready); end
        mm_valid = 1'b1; mm_result = 8'hEE;
        tick();
        total++; if (mm_start !== 1'b0 || mm_x_valid !== 1'b0) begin bad++;
            $display("FAIL gap_cycle got start=%b xv=%b want 0 0", mm_start, mm_x_valid); end
        tick();
        for (int i = 0; i < N; i++) begin
            if (i == abort_at) begin
                rst_n = 1'b1;
                #1;
                total++; if (mm_x_valid !== 1'b0 || mm_y_valid !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || mm_start !== 1'b0 || op_ready !== 1'b0) begin bad++;
                    $display("FAIL async_abort got xv=%b yv=%b busy=%b rv=%b st=%b rdy=%b want all 0", mm_x_valid, mm_y_valid, busy, res_valid, mm_start, op_ready); end
                exp_x.delete(); exp_y.delete();
                mm_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b0;
                tick();
                total++; if (op_ready !== 1'b1 || res_valid !== 1'b0) begin bad++;
                    $display("FAIL abort_recover got rdy=%b rv=%b want 1 0", op_ready, res_valid); end
                return;
            end
            ex = exp_x.pop_front();
            ey = exp_y.pop_front();
            total++; if (mm_x_valid !== 1'b1 || mm_y_valid !== 1'b1 || mm_x !== ex || mm_y !== ey) begin bad++;
                $display("FAIL send_word%0d got xv=%b yv=%b x=%h y=%h want 1 1 %h %h", i, mm_x_valid, mm_y_valid, mm_x, mm_y, ex, ey); end
            tick();
        end
        mm_valid = 1'b0;
        total++; if (mm_x_valid !== 1'b0 || mm_y_valid !== 1'b0 || res_valid !== 1'b0) begin bad++;
            $display("FAIL send_end got xv=%b yv=%b rv=%b want 0 0 0", mm_x_valid, mm_y_valid, res_valid); end
        if (starve) begin
`ifdef MM_TIMEOUT_EN
            t = 0;
            while (timeout_err !== 1'b1 && t < 40) begin
                tick(); t++;
                total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL starve_rv got=%b want=0", res_valid); end
            end
            total++; if (t !== 16 || op_ready !== 1'b1 || busy !== 1'b0) begin bad++;
                $display("FAIL timeout_at got cycle=%0d rdy=%b busy=%b want 16 1 0", t, op_ready, busy); end
            tick();
            total++; if (timeout_err !== 1'b0 || res_valid !== 1'b0) begin bad++;
                $display("FAIL timeout_pulse got terr=%b rv=%b want 0 0", timeout_err, res_valid); end
`endif
            return;
        end
        for (int c = 0; c < 9; c++) tick();
        exp_res.push_back(r);
        w = 0;
        plen = gapped ? 7 : 4;
        for (int c = 0; c < plen; c++) begin
            v = gapped ? gpat[c] : 1'b1;
            mm_valid = v;
            mm_result = v ? r[w*K +: K] : 8'h5A;
            if (v) w++;
            tick();
            if (c < plen - 1) begin
                total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL early_rv c=%0d got=%b want=0", c, res_valid); end
            end
        end
        mm_valid = 1'b0;
        total++; if (res_valid !== 1'b1 || res_data !== exp_res[0]) begin bad++;
            $display("FAIL result got rv=%b data=%h want 1 %h", res_valid, res_data, exp_res[0]); end
        for (int c = 0; c < hold; c++) begin
            op_valid = 1'b1; op_x = 32'hDEADBEEF; op_y = 32'hCAFEF00D;
            tick();
            total++; if (res_valid !== 1'b1 || res_data !== exp_res[0] || op_ready !== 1'b0 || mm_start !== 1'b0) begin bad++;
                $display("FAIL hold%0d got rv=%b data=%h rdy=%b st=%b want 1 %h 0 0", c, res_valid, res_data, op_ready, mm_start, exp_res[0]); end
        end
        void'(exp_res.pop_front());
        op_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        total++; if (res_valid !== 1'b0 || op_ready !== 1'b1 || busy !== 1'b0) begin bad++;
            $display("FAIL release got rv=%b rdy=%b busy=%b want 0 1 0", res_valid, op_ready, busy); end
    endtask

    task automatic test_reset();
        tick(); tick();
        total++; if (mm_start !== 1'b0 || mm_x_valid !== 1'b0 || mm_y_valid !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b0) begin bad++;
            $display("FAIL reset_ctrl got st=%b xv=%b yv=%b rv=%b busy=%b rdy=%b want all 0", mm_start, mm_x_valid, mm_y_valid, res_valid, busy, op_ready); end
        total++; if (mm_x !== 8'h00 || mm_y !== 8'h00 || res_data !== 32'h0) begin bad++;
            $display("FAIL reset_data got x=%h y=%h res=%h want 0", mm_x, mm_y, res_data); end
`ifdef MM_TIMEOUT_EN
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_terr got=%b want=0", timeout_err); end
`endif
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL pre_clock_rdy got=%b want=0", op_ready); end
        tick();
        total++; if (op_ready !== 1'b1 || busy !== 1'b0) begin bad++;
            $display("FAIL first_clock_rdy got rdy=%b busy=%b want 1 0", op_ready, busy); end
    endtask

    task automatic test_basic();
        run_job(32'h44332211, 32'h88776655, 32'hD4C3B2A1, 1'b0, 0, -1, 1'b0);
    endtask

    task automatic test_gapped_result();
        run_job(32'h0F1E2D3C, 32'h99AABBCC, 32'hD4C3B2A1, 1'b1, 0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_job(32'h01020304, 32'hF0E0D0C0, 32'h13579BDF, 1'b0, 20, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_job(32'hA5A55A5A, 32'h3C3CC3C3, 32'h76543210, 1'b1, 0, -1, 1'b0);
        run_job(32'hFFFFFFFF, 32'h00000000, 32'h80000001, 1'b0, 0, -1, 1'b0);
    endtask

    task automatic test_reset_abort();
        run_job(32'h11223344, 32'h55667788, 32'h0, 1'b0, 0, 2, 1'b0);
        run_job(32'h44332211, 32'h88776655, 32'hD4C3B2A1, 1'b0, 0, -1, 1'b0);
    endtask

`ifdef MM_TIMEOUT_EN
    task automatic test_timeout();
        run_job(32'h12345678, 32'h9ABCDEF0, 32'h0, 1'b0, 0, -1, 1'b1);
        run_job(32'h44332211, 32'h88776655, 32'hD4C3B2A1, 1'b0, 0, -1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gapped_result();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
`ifdef MM_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
